// File: rtl/capture_if.sv
// Control bundle between the LA sampler/command path and the capture sequencer.
// The sequencer attaches through the slave modport; the host side uses master.
`timescale 1ns/1ps
interface capture_if #(
  parameter int AW = 9
);
  logic          run;
  logic          wrt_smpl;
  logic          triggered;
  logic [AW-1:0] trig_pos;
  logic          clr_cap_done;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          capture_done;
  logic [AW-1:0] trig_ptr;

  modport master (
    output run, wrt_smpl, triggered, trig_pos, clr_cap_done,
    input  we, waddr, armed, capture_done, trig_ptr
  );

  modport slave (
    input  run, wrt_smpl, triggered, trig_pos, clr_cap_done,
    output we, waddr, armed, capture_done, trig_ptr
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer for the LA sample RAM: fills a circular pre-trigger history,
// counts post-trigger samples, then freezes the buffer and reports the dump start.
`timescale 1ns/1ps
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int AW      = 9
) (
  input  logic     clk,
  input  logic     rst_n,
  capture_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [AW:0]   ENT_W     = (AW+1)'(ENTRIES);
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_LAST = AW'(ENTRIES - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic [AW:0]   smpl_cnt_q, smpl_cnt_d;
  logic [AW:0]   post_cnt_q, post_cnt_d;
  logic          armed_q, armed_d;
  logic          done_q, done_d;
  logic [AW-1:0] waddr_inc_s;
  logic [AW:0]   tp_clamp_s;
  logic [AW:0]   arm_thr_s;
  logic          we_s;

  // Post-trigger depth clamped so at least one pre-trigger sample is always kept.
  assign tp_clamp_s  = ({1'b0, bus.trig_pos} >= ENT_W) ? (ENT_W - CNT_ONE) : {1'b0, bus.trig_pos};
  assign arm_thr_s   = ENT_W - tp_clamp_s;
  assign waddr_inc_s = (waddr_q == ADDR_LAST) ? ADDR_ZERO : (waddr_q + ADDR_ONE);
  assign we_s        = bus.wrt_smpl & ((state_q == ST_PRE) | (state_q == ST_POST));

  // Next-state, address/counter update and capture bookkeeping.
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    trig_ptr_d = trig_ptr_q;
    smpl_cnt_d = smpl_cnt_q;
    post_cnt_d = post_cnt_q;
    armed_d    = armed_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        waddr_d    = ADDR_ZERO;
        smpl_cnt_d = CNT_ZERO;
        post_cnt_d = CNT_ZERO;
        armed_d    = 1'b0;
        if (bus.run) begin
          state_d = ST_PRE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (!bus.run) begin
          state_d    = ST_IDLE;
          waddr_d    = ADDR_ZERO;
          smpl_cnt_d = CNT_ZERO;
          post_cnt_d = CNT_ZERO;
          armed_d    = 1'b0;
        end else begin
          if (bus.wrt_smpl) begin
            waddr_d    = waddr_inc_s;
            smpl_cnt_d = (smpl_cnt_q == ENT_W) ? ENT_W : (smpl_cnt_q + CNT_ONE);
          end else begin
            waddr_d    = waddr_q;
            smpl_cnt_d = smpl_cnt_q;
          end
          if (smpl_cnt_d >= arm_thr_s) begin
            armed_d = 1'b1;
          end else begin
            armed_d = armed_q;
          end
          // The registered armed flag qualifies the trigger; a same-cycle write stays pre-trigger.
          if (bus.triggered && armed_q) begin
            if (tp_clamp_s == CNT_ZERO) begin
              state_d    = ST_DONE;
              done_d     = 1'b1;
              trig_ptr_d = waddr_d;
            end else begin
              state_d    = ST_POST;
              post_cnt_d = CNT_ZERO;
            end
          end else begin
            state_d = ST_PRE;
          end
        end
      end
      ST_POST: begin
        if (!bus.run) begin
          state_d    = ST_IDLE;
          waddr_d    = ADDR_ZERO;
          smpl_cnt_d = CNT_ZERO;
          post_cnt_d = CNT_ZERO;
          armed_d    = 1'b0;
        end else if (bus.wrt_smpl) begin
          waddr_d    = waddr_inc_s;
          post_cnt_d = post_cnt_q + CNT_ONE;
          if (post_cnt_d == tp_clamp_s) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            trig_ptr_d = waddr_d;
          end else begin
            state_d = ST_POST;
          end
        end else begin
          state_d = ST_POST;
        end
      end
      ST_DONE: begin
        if (bus.clr_cap_done) begin
          state_d    = ST_IDLE;
          done_d     = 1'b0;
          waddr_d    = ADDR_ZERO;
          smpl_cnt_d = CNT_ZERO;
          post_cnt_d = CNT_ZERO;
          armed_d    = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        done_d     = 1'b0;
        waddr_d    = ADDR_ZERO;
        smpl_cnt_d = CNT_ZERO;
        post_cnt_d = CNT_ZERO;
        armed_d    = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      waddr_q    <= ADDR_ZERO;
      trig_ptr_q <= ADDR_ZERO;
      smpl_cnt_q <= CNT_ZERO;
      post_cnt_q <= CNT_ZERO;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      trig_ptr_q <= trig_ptr_d;
      smpl_cnt_q <= smpl_cnt_d;
      post_cnt_q <= post_cnt_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
    end
  end

  assign bus.we           = we_s;
  assign bus.waddr        = waddr_q;
  assign bus.armed        = armed_q;
  assign bus.capture_done = done_q;
  assign bus.trig_ptr     = trig_ptr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: a sample-count reference model queues the
// expected outputs per cycle, and an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_capture_ctrl;
  localparam int E  = 384;
  localparam int AW = 9;
  localparam int P_IDLE = 0, P_PRE = 1, P_POST = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst_n;
  capture_if #(.AW(AW)) bus();
  capture_ctrl #(.ENTRIES(E), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic          armed;
    logic          done;
    logic [AW-1:0] tptr;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int we_cnt = 0;
  bit saw_wrap = 1'b0;
  logic [AW-1:0] last_wa = '0;
  // Reference model: total writes since the capture started; address is writes mod depth.
  int m_phase, m_wr, m_post, m_tptr, tp;
  bit m_armed, m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v >= E) ? E - 1 : v;
  endfunction

  task automatic go_idle();
    m_phase = P_IDLE; m_wr = 0; m_post = 0; m_armed = 1'b0; m_done = 1'b0;
  endtask

  task automatic finish_cap();
    m_phase = P_DONE; m_done = 1'b1; m_tptr = m_wr % E;
  endtask

  task automatic model_next(input bit r, input bit w, input bit t, input bit c);
    int  cp;
    bit  acc;
    cp = clampv(tp);
    case (m_phase)
      P_IDLE: begin
        go_idle();
        if (r) m_phase = P_PRE;
      end
      P_PRE: begin
        if (!r) go_idle();
        else begin
          acc = t && m_armed;
          if (w) m_wr++;
          if (((m_wr < E) ? m_wr : E) >= E - cp) m_armed = 1'b1;
          if (acc) begin
            if (cp == 0) finish_cap();
            else begin m_phase = P_POST; m_post = 0; end
          end
        end
      end
      P_POST: begin
        if (!r) go_idle();
        else if (w) begin
          m_wr++; m_post++;
          if (m_post == cp) finish_cap();
        end
      end
      default: begin
        if (c) go_idle();
      end
    endcase
  endtask

  task automatic step(input bit r, input bit w, input bit t, input bit c);
    exp_t e;
    @(posedge clk); #1;
    bus.run = r; bus.wrt_smpl = w; bus.triggered = t; bus.clr_cap_done = c;
    bus.trig_pos = AW'(tp);
    e.we    = w && (m_phase == P_PRE || m_phase == P_POST);
    e.waddr = AW'(m_wr % E);
    e.armed = m_armed;
    e.done  = m_done;
    e.tptr  = AW'(m_tptr);
    exp_q.push_back(e);
    model_next(r, w, t, c);
  endtask

  task automatic writes(input int n, input bit t, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmax, gmin)) step(1'b1, 1'b0, t, 1'b0);
      step(1'b1, 1'b1, t, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    bus.run = 1'b0; bus.wrt_smpl = 1'b0; bus.triggered = 1'b0; bus.clr_cap_done = 1'b0;
    #1;
    chk("rst_we",    32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_armed", 32'(bus.armed), 32'd0);
    chk("rst_done",  32'(bus.capture_done), 32'd0);
    chk("rst_tptr",  32'(bus.trig_ptr), 32'd0);
    go_idle(); m_tptr = 0;
    @(posedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle; also tracks RAM writes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.we === 1'b1) begin
        if (last_wa == AW'(E - 1) && bus.waddr == '0) saw_wrap = 1'b1;
        last_wa = bus.waddr;
        we_cnt++;
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("we",    32'(bus.we), 32'(e.we));
        chk("waddr", 32'(bus.waddr), 32'(e.waddr));
        chk("armed", 32'(bus.armed), 32'(e.armed));
        chk("capture_done", 32'(bus.capture_done), 32'(e.done));
        if (e.done) chk("trig_ptr", 32'(bus.trig_ptr), 32'(e.tptr));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; tp = 0;
    bus.run = 1'b0; bus.wrt_smpl = 1'b0; bus.triggered = 1'b0; bus.clr_cap_done = 1'b0;
    bus.trig_pos = '0;
    go_idle(); m_tptr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_waddr", 32'(bus.waddr), 32'd0);
    chk("init_done",  32'(bus.capture_done), 32'd0);
    chk("init_armed", 32'(bus.armed), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Arming with trigger held from the start, strobe every 4 clks.
    tp = 128;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 256; i++) begin
      repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
    end
    #1 chk("arm_at_256th", 32'(bus.armed), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    #1 chk("arm_rise", 32'(bus.armed), 32'd1);
    for (int i = 0; i < 128; i++) begin
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("arm_cap_done", 32'(bus.capture_done), 32'd1);
    chk("arm_tptr", 32'(bus.trig_ptr), 32'd0);
    // Release with run still high.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("rel_done", 32'(bus.capture_done), 32'd0);
    chk("rel_waddr", 32'(bus.waddr), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("rel_reenter_we", 32'(bus.we), 32'd1);

    // Full capture: trigger after 300 writes, 128 post writes.
    do_reset();
    saw_wrap = 1'b0; last_wa = '0; tp = 128;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    base = we_cnt;
    writes(300, 1'b0, 0, 2);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    writes(128, 1'b0, 0, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("full_done", 32'(bus.capture_done), 32'd1);
    chk("full_tptr", 32'(bus.trig_ptr), 32'd44);
    chk("full_we_count", 32'(we_cnt - base), 32'd428);
    chk("full_wrap", 32'(saw_wrap), 32'd1);
    repeat (3) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      #1 chk("full_we_frozen", 32'(bus.we), 32'd0);
    end

    // Abort after 50 post-trigger writes.
    do_reset();
    tp = 100;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    writes(284, 1'b0, 0, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    writes(50, 1'b0, 0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("abort_armed", 32'(bus.armed), 32'd0);
    chk("abort_done", 32'(bus.capture_done), 32'd0);
    chk("abort_waddr", 32'(bus.waddr), 32'd0);
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0);

    // Zero post-trigger depth.
    do_reset();
    tp = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    base = we_cnt;
    writes(384, 1'b1, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    #1 chk("zero_armed", 32'(bus.armed), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("zero_done", 32'(bus.capture_done), 32'd1);
    chk("zero_tptr", 32'(bus.trig_ptr), 32'd0);
    chk("zero_no_we", 32'(bus.we), 32'd0);
    chk("zero_we_count", 32'(we_cnt - base), 32'd384);

    // trig_pos beyond depth clamps to ENTRIES-1.
    do_reset();
    tp = 450;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    writes(1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    writes(383, 1'b0, 0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("clamp_done", 32'(bus.capture_done), 32'd1);
    chk("clamp_tptr", 32'(bus.trig_ptr), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-POST, then restart from address 0.
    do_reset();
    tp = 128;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    writes(260, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    writes(20, 1'b0, 0, 0);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("restart_we", 32'(bus.we), 32'd1);
    chk("restart_waddr", 32'(bus.waddr), 32'd0);

    // Random soak against the model.
    do_reset();
    repeat (4000) begin
      if ((m_phase == P_IDLE || m_phase == P_DONE) && $urandom_range(7, 0) == 0)
        tp = int'($urandom_range(511, 0));
      step($urandom_range(999, 0) != 0, $urandom_range(1, 0) == 1,
           $urandom_range(29, 0) == 0, $urandom_range(24, 0) == 0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Capture sequencer for the logic-analyzer sample RAM inside LA_dig. It gates and addresses RAM writes from the decimated sample strobe. It arms once enough pre-trigger history is stored, then counts the post-trigger samples. At the end it freezes the buffer and flags capture_done for the host command path to poll and dump.

## Interface
- ENTRIES, 384, sample RAM depth in samples (per channel).
- AW, 9, address width; ENTRIES <= 2^AW.

- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  capture enable (TrigCfg run bit), level-sensitive.
- wrt_smpl  in  1  one-clk strobe: a decimated sample is present this cycle.
- triggered  in  1  trigger-logic result, level, ignored unless armed.
- trig_pos  in  AW  post-trigger samples to keep; values >= ENTRIES clamp to ENTRIES-1.
- clr_cap_done  in  1  one-clk pulse from command path; releases a finished capture.
- we  out  1  RAM write enable.
- waddr  out  AW  RAM write address.
- armed  out  1  pre-trigger history requirement met.
- capture_done  out  1  capture complete, buffer frozen.
- trig_ptr  out  AW  address of oldest sample in frozen buffer (dump start).

## Operation
- States: IDLE, PRE, POST, DONE.
- IDLE:
  - waddr=0, smpl_cnt=0, post_cnt=0, armed=0.
  - run=1 -> PRE.
- PRE:
  - Each wrt_smpl: we=1 at waddr, then waddr advances; wrap ENTRIES-1 -> 0.
  - smpl_cnt increments, saturating at ENTRIES.
  - armed sets when smpl_cnt >= ENTRIES - trig_pos (counted after the current write) and stays set until IDLE.
  - triggered && armed -> POST; post_cnt=0.
  - A sample written in the same cycle as the trigger counts as pre-trigger.
- POST:
  - Each wrt_smpl: write and advance as in PRE; post_cnt++.
  - Leaves for DONE on the write that makes post_cnt == trig_pos.
  - trig_pos==0: PRE goes directly to DONE on the trigger cycle, with no further writes.
- DONE:
  - we=0; waddr frozen.
  - capture_done=1; trig_ptr=waddr (next write slot = oldest sample).
  - clr_cap_done -> IDLE; capture_done clears.
  - run level is ignored in DONE.
- Abort: run=0 in PRE or POST -> IDLE with no capture_done. run=0 in IDLE keeps IDLE.
- triggered while not armed has no effect.
- clr_cap_done outside DONE is ignored.

## Timing
- Reset values: state=IDLE, we=0, waddr=0, armed=0, capture_done=0, trig_ptr=0, all counters 0.
- we = wrt_smpl & (state==PRE | state==POST), combinational.
- waddr is registered; it is valid during the we cycle and updates on the following edge.
- IDLE->PRE takes 1 clk after run is sampled high. A wrt_smpl in the IDLE cycle is not written.
- armed is registered: it asserts the clk after the qualifying write.
- Trigger qualification uses the registered armed value, so the earliest trigger acceptance is 1 clk after armed rises.
- capture_done and trig_ptr are registered: they assert 1 clk after the final POST write, or 1 clk after the trigger when trig_pos==0.
- Reset mid-operation returns to reset values immediately (async); no partial capture_done.
- Arithmetic: all compares are unsigned AW+1 bits. ENTRIES - trig_pos uses the clamped trig_pos.

## Test plan
- Arming: ENTRIES=384, trig_pos=128, run=1, wrt_smpl every 4 clks, triggered held 1 from the start.
  - Required: armed rises 1 clk after the 256th write; no POST before that.
- Full capture: trig_pos=128, trigger asserted after the 300th write, then 128 more strobes.
  - Required: exactly 428 we pulses; waddr wraps 383->0.
  - Required: capture_done=1 1 clk after the last write; trig_ptr=44; we stays 0 after that.
- Release: in DONE, pulse clr_cap_done.
  - Required: next clk capture_done=0 and waddr=0.
  - Required: with run still 1, the block re-enters PRE the following clk.
- Abort: drop run after 50 POST writes.
  - Required: IDLE next clk; capture_done never asserts; armed=0.
- Zero post-trigger: trig_pos=0; trigger at the first armed cycle (after 384 writes).
  - Required: capture_done 1 clk later, no additional we, trig_ptr=0.
- Reset: assert rst_n=0 mid-POST.
  - Required: all outputs return to reset values asynchronously.
  - Required: a subsequent run=1 restarts at waddr=0.
